// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: active-low row drive, synchronized column sampling,
// tick-based debounce and one key event per press. Define KEY_REPEAT_EN for auto-repeat.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8,
  parameter int REPEAT_DIV   = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV) + 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CNT) + 1;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

  state_t            state, state_next;
  logic [3:0]        col_meta, cs;
  logic [DIV_W-1:0]  div_cnt;
  logic [1:0]        row_idx, col_idx, low_col, accept_col;
  logic [DB_W-1:0]   stable_cnt, rel_cnt;
  logic              tick, col_low;
  logic              latch_key, accept, advance, release_key, rep_pulse;

  assign tick    = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign col_low = ~cs[col_idx];
  assign row     = ~(4'b0001 << row_idx);

  // Lowest-indexed low column wins when several keys share the scanned row.
  always_comb begin
    if      (!cs[0]) low_col = 2'd0;
    else if (!cs[1]) low_col = 2'd1;
    else if (!cs[2]) low_col = 2'd2;
    else             low_col = 2'd3;
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no latch can be inferred.
    state_next  = state;
    latch_key   = 1'b0;
    accept      = 1'b0;
    advance     = 1'b0;
    release_key = 1'b0;
    accept_col  = col_idx;
    case (state)
      SCAN: if (tick) begin
        if (cs == 4'hF) begin
          advance = 1'b1;
        end else begin
          latch_key  = 1'b1;
          accept_col = low_col;
          if (DEBOUNCE_CNT == 1) begin
            accept     = 1'b1;
            state_next = HOLD;
          end else begin
            state_next = DEBOUNCE;
          end
        end
      end
      DEBOUNCE: if (tick) begin
        if (col_low) begin
          if (stable_cnt == DB_W'(DEBOUNCE_CNT - 1)) begin
            accept     = 1'b1;
            state_next = HOLD;
          end
        end else begin
          advance    = 1'b1;
          state_next = SCAN;
        end
      end
      HOLD: if (tick && !col_low && rel_cnt == DB_W'(DEBOUNCE_CNT - 1)) begin
        release_key = 1'b1;
        advance     = 1'b1;
        state_next  = SCAN;
      end
      default: state_next = SCAN;
    endcase
  end

`ifdef KEY_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DIV) + 1;
  logic [REP_W-1:0] rep_cnt;

  assign rep_pulse = (state == HOLD) && tick && !release_key &&
                     (rep_cnt == REP_W'(REPEAT_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || accept || release_key)    rep_cnt <= '0;
    else if (state == HOLD && tick)      rep_cnt <= rep_pulse ? '0 : rep_cnt + 1'b1;
  end
`else
  assign rep_pulse = 1'b0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state      <= SCAN;
      col_meta   <= 4'hF;
      cs         <= 4'hF;
      div_cnt    <= '0;
      row_idx    <= '0;
      col_idx    <= '0;
      stable_cnt <= '0;
      rel_cnt    <= '0;
      key_valid  <= 1'b0;
      key_code   <= '0;
      key_held   <= 1'b0;
    end else begin
      state     <= state_next;
      col_meta  <= col;
      cs        <= col_meta;
      div_cnt   <= tick ? '0 : div_cnt + 1'b1;
      key_valid <= accept | rep_pulse;

      if (advance) row_idx <= row_idx + 1'b1;

      if (latch_key) begin
        col_idx    <= low_col;
        stable_cnt <= DB_W'(1);
      end else if (state == DEBOUNCE && tick && col_low &&
                   stable_cnt != DB_W'(DEBOUNCE_CNT)) begin
        stable_cnt <= stable_cnt + 1'b1;
      end

      if (accept) begin
        key_code <= {row_idx, accept_col};
        key_held <= 1'b1;
        rel_cnt  <= '0;
      end else if (state == HOLD && tick) begin
        // Any low sample of the tracked column restarts the release count.
        if (col_low || release_key) rel_cnt <= '0;
        else                        rel_cnt <= rel_cnt + 1'b1;
        if (release_key)            key_held <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a combinational 4x4 keypad model.
// Expects KEY_REPEAT_EN to be defined identically for bench and RTL.
module tb_keypad_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;

  logic [15:0] pressed   = '0;
  logic [3:0]  col_force = 4'hF;

  int checks   = 0;
  int failures = 0;

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CNT(3), .REPEAT_DIV(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .row       (row),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // A pressed key pulls its column low only while its row is driven low.
  always_comb begin
    col = col_force;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && pressed[r*4+c]) col[c] = 1'b0;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int pulses;
    int last_code;
    int codes_ok;
    int waited;
    int rel_row;
    int exp_pulses;

`ifdef KEY_REPEAT_EN
    exp_pulses = 5;
`else
    exp_pulses = 1;
`endif

    // Reset values
    step(3);
    check("rst_row", row, 4'b1110);
    check("rst_valid", key_valid, 1'b0);
    check("rst_code", key_code, 4'd0);
    check("rst_held", key_held, 1'b0);
    rst = 1'b0;

    // Idle rotation, one row per 4 clocks
    step(4); check("rot_row1", row, 4'b1101);
    step(4); check("rot_row2", row, 4'b1011);
    step(4); check("rot_row3", row, 4'b0111);
    step(4); check("rot_row0", row, 4'b1110);

    // Single press row2/col1
    pressed = 16'h0200;
    pulses = 0; last_code = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (key_valid) begin pulses++; last_code = key_code; end
    end
    check("press_pulses", pulses, 1);
    check("press_code", last_code, 9);
    check("press_held", key_held, 1'b1);
    check("press_row_frozen", row, 4'b1011);

    // Release: held drops after three high ticks, scanning resumes at row3
    pressed = '0;
    waited = 0; rel_row = -1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (rel_row < 0) begin
        waited++;
        if (!key_held) rel_row = row;
      end
    end
    check("rel_held", key_held, 1'b0);
    check("rel_row3", rel_row, 4'b0111);
    check("rel_not_early", (waited >= 9), 1'b1);
    check("rel_code_kept", key_code, 4'd9);

    // Glitch on col1 while row0 is driven: sync to the start of a row0 slot
    waited = 0;
    while (row == 4'b1110 && waited < 20) begin step(1); waited++; end
    while (row != 4'b1110 && waited < 40) begin step(1); waited++; end
    check("glitch_sync", row, 4'b1110);
    col_force = 4'b1101;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (key_valid) pulses++;
    end
    col_force = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (key_valid) pulses++;
    end
    check("glitch_row1", row, 4'b1101);
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (key_valid) pulses++;
    end
    check("glitch_no_event", pulses, 0);
    check("glitch_held", key_held, 1'b0);

    // Row1 cols 0 and 3 together: lowest column wins, one event
    pressed = 16'h0090;
    pulses = 0; last_code = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (key_valid) begin pulses++; last_code = key_code; end
    end
    check("multi_pulses", pulses, 1);
    check("multi_code", last_code, 4);
    pressed = '0;
    step(24);
    check("multi_released", key_held, 1'b0);

    // Reset in the middle of HOLD
    pressed = 16'h0040;
    waited = 0;
    while (!key_held && waited < 40) begin step(1); waited++; end
    check("hold_reached", key_held, 1'b1);
    step(3);
    rst = 1'b1;
    step(1);
    check("midrst_row", row, 4'b1110);
    check("midrst_held", key_held, 1'b0);
    check("midrst_valid", key_valid, 1'b0);
    check("midrst_code", key_code, 4'd0);
    rst = 1'b0;
    pressed = '0;
    step(8);

    // Hold row3/col3 for 20 ticks after accept
    pressed = 16'h8000;
    waited = 0;
    while (!key_valid && waited < 40) begin step(1); waited++; end
    check("rep_first", key_valid, 1'b1);
    pulses = 1;
    codes_ok = (key_code == 4'd15);
    for (int i = 0; i < 80; i++) begin
      step(1);
      if (key_valid) begin
        pulses++;
        if (key_code != 4'd15) codes_ok = 0;
      end
    end
    check("rep_pulses", pulses, exp_pulses);
    check("rep_codes", codes_ok, 1);
    pressed = '0;
    step(24);
    check("rep_released", key_held, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
